// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard unit between decode and execute/memory/writeback. Each register
// has a pending-write counter; memory ops and control transfers are tracked too.
module hazard_scoreboard #(
   parameter int REGS         = 32,
   parameter int ADDR_WIDTH   = 5,
   parameter int CNT_WIDTH    = 2,
   parameter int MEM_MAX      = 1,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  issue_valid,
   output logic                  issue_ready,
   input  logic [ADDR_WIDTH-1:0] issue_rs1,
   input  logic                  issue_rs1_used,
   input  logic [ADDR_WIDTH-1:0] issue_rs2,
   input  logic                  issue_rs2_used,
   input  logic [ADDR_WIDTH-1:0] issue_rd,
   input  logic                  issue_rd_wen,
   input  logic                  issue_mem,
   input  logic                  issue_ctrl,
   input  logic                  retire_valid,
   input  logic [ADDR_WIDTH-1:0] retire_rd,
   input  logic                  mem_done,
   input  logic                  ctrl_resolve,
   input  logic                  ctrl_taken,
   output logic                  bubble,
   output logic [1:0]            stall_cause,
   output logic                  error
);

   localparam int                    ENTRIES  = 2 ** ADDR_WIDTH;
   localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;
   localparam logic [ADDR_WIDTH:0]   REGS_LIM = (ADDR_WIDTH + 1)'(REGS);

   logic [CNT_WIDTH-1:0] pending [ENTRIES];
   logic [2:0]           mem_count;
   logic                 ctrl_pending;
   logic [3:0]           shadow;
   logic                 error_q;

   logic stall_ctrl;
   logic stall_raw;
   logic stall_struct;
   logic fire;
   logic retire_ok;
   logic retire_bad;
   logic mem_inc;
   logic mem_dec;

   // Register 0 and indices beyond the register file never hold a pending write.
   function automatic logic tracked(input logic [ADDR_WIDTH-1:0] idx);
      return (idx != '0) && ({1'b0, idx} < REGS_LIM);
   endfunction

   assign stall_ctrl   = ctrl_pending || (shadow != 4'd0);
   assign stall_raw    = (issue_rs1_used && tracked(issue_rs1) && (pending[issue_rs1] != '0)) ||
                         (issue_rs2_used && tracked(issue_rs2) && (pending[issue_rs2] != '0));
   assign stall_struct = (issue_rd_wen && tracked(issue_rd) && (pending[issue_rd] == CNT_MAX)) ||
                         (issue_mem && (mem_count == 3'(MEM_MAX)));

   assign issue_ready = !(stall_ctrl || stall_raw || stall_struct);
   assign fire        = issue_valid && issue_ready;
   assign bubble      = issue_valid && !issue_ready;
   assign error       = error_q;

   assign retire_ok  = retire_valid && tracked(retire_rd) && (pending[retire_rd] != '0);
   assign retire_bad = retire_valid && (retire_rd != '0) && !retire_ok;
   assign mem_inc    = fire && issue_mem;
   assign mem_dec    = mem_done && (mem_count != 3'd0);

   always_comb begin
      stall_cause = 2'd0;
      if (stall_ctrl)
         stall_cause = 2'd3;
      else if (stall_raw)
         stall_cause = 2'd1;
      else if (stall_struct)
         stall_cause = 2'd2;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++)
            pending[i] <= '0;
         mem_count    <= 3'd0;
         ctrl_pending <= 1'b0;
         shadow       <= 4'd0;
         error_q      <= 1'b0;
      end else begin
         // An issue and a retire hitting the same register in one cycle cancel out.
         for (int i = 1; i < ENTRIES; i++) begin
            if (i < REGS) begin
               if ((fire && issue_rd_wen && (issue_rd == ADDR_WIDTH'(i))) &&
                   !(retire_ok && (retire_rd == ADDR_WIDTH'(i))))
                  pending[i] <= pending[i] + CNT_WIDTH'(1);
               else if ((retire_ok && (retire_rd == ADDR_WIDTH'(i))) &&
                        !(fire && issue_rd_wen && (issue_rd == ADDR_WIDTH'(i))))
                  pending[i] <= pending[i] - CNT_WIDTH'(1);
            end
         end

         if (mem_inc && !mem_dec)
            mem_count <= mem_count + 3'd1;
         else if (mem_dec && !mem_inc)
            mem_count <= mem_count - 3'd1;

         if (fire && issue_ctrl)
            ctrl_pending <= 1'b1;
         else if (ctrl_resolve)
            ctrl_pending <= 1'b0;

         if (ctrl_resolve && ctrl_taken)
            shadow <= 4'(FLUSH_CYCLES);
         else if (shadow != 4'd0)
            shadow <= shadow - 4'd1;

         error_q <= error_q || retire_bad ||
                    (mem_done && (mem_count == 3'd0)) ||
                    (ctrl_resolve && !ctrl_pending);
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: each step drives inputs at the falling edge
// and checks the combinational outputs shortly after, before the next rising edge.
module tb_hazard_scoreboard;

   logic       clk = 1'b0;
   logic       reset;
   logic       issue_valid;
   logic       issue_ready;
   logic [4:0] issue_rs1;
   logic       issue_rs1_used;
   logic [4:0] issue_rs2;
   logic       issue_rs2_used;
   logic [4:0] issue_rd;
   logic       issue_rd_wen;
   logic       issue_mem;
   logic       issue_ctrl;
   logic       retire_valid;
   logic [4:0] retire_rd;
   logic       mem_done;
   logic       ctrl_resolve;
   logic       ctrl_taken;
   logic       bubble;
   logic [1:0] stall_cause;
   logic       error;

   int checks   = 0;
   int failures = 0;

   hazard_scoreboard #(
      .REGS(32), .ADDR_WIDTH(5), .CNT_WIDTH(2), .MEM_MAX(1), .FLUSH_CYCLES(2)
   ) dut (
      .clk(clk), .reset(reset),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_rs1(issue_rs1), .issue_rs1_used(issue_rs1_used),
      .issue_rs2(issue_rs2), .issue_rs2_used(issue_rs2_used),
      .issue_rd(issue_rd), .issue_rd_wen(issue_rd_wen),
      .issue_mem(issue_mem), .issue_ctrl(issue_ctrl),
      .retire_valid(retire_valid), .retire_rd(retire_rd),
      .mem_done(mem_done), .ctrl_resolve(ctrl_resolve), .ctrl_taken(ctrl_taken),
      .bubble(bubble), .stall_cause(stall_cause), .error(error)
   );

   always #5 clk = ~clk;

   // Drives the issue side and clears the retire/resolve side for this cycle.
   task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2,
                                input logic [4:0] rd, input logic wen,
                                input logic mem, input logic ctrl);
      @(negedge clk);
      issue_valid    = v;
      issue_rs1      = rs1;
      issue_rs1_used = u1;
      issue_rs2      = rs2;
      issue_rs2_used = u2;
      issue_rd       = rd;
      issue_rd_wen   = wen;
      issue_mem      = mem;
      issue_ctrl     = ctrl;
      retire_valid   = 1'b0;
      retire_rd      = 5'd0;
      mem_done       = 1'b0;
      ctrl_resolve   = 1'b0;
      ctrl_taken     = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic exp_ready, input logic exp_bubble,
                              input logic [1:0] exp_cause, input logic exp_error);
      #1;
      checks++;
      assert (issue_ready === exp_ready) else begin
         failures++;
         $error("[TB] FAIL %s issue_ready observed=%b expected=%b", tag, issue_ready, exp_ready);
      end
      checks++;
      assert (bubble === exp_bubble) else begin
         failures++;
         $error("[TB] FAIL %s bubble observed=%b expected=%b", tag, bubble, exp_bubble);
      end
      checks++;
      assert (stall_cause === exp_cause) else begin
         failures++;
         $error("[TB] FAIL %s stall_cause observed=%0d expected=%0d", tag, stall_cause, exp_cause);
      end
      checks++;
      assert (error === exp_error) else begin
         failures++;
         $error("[TB] FAIL %s error observed=%b expected=%b", tag, error, exp_error);
      end
   endtask

   initial begin
      reset = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b0;
      checkOutput("reset_idle", 1, 0, 0, 0);

      // Independent instruction issues; its rd=7 becomes pending.
      applyStimulus(1, 5, 1, 6, 1, 7, 1, 0, 0);
      checkOutput("first_issue", 1, 0, 0, 0);
      applyStimulus(1, 7, 1, 0, 0, 0, 0, 0, 0);
      retire_valid = 1'b1; retire_rd = 5'd7;
      checkOutput("raw_r7", 0, 1, 1, 0);
      applyStimulus(1, 7, 1, 0, 0, 0, 0, 0, 0);
      checkOutput("r7_cleared", 1, 0, 0, 0);

      // RAW on r3; retire in the same cycle must not bypass.
      applyStimulus(1, 0, 0, 0, 0, 3, 1, 0, 0);
      checkOutput("issue_rd3", 1, 0, 0, 0);
      applyStimulus(1, 3, 1, 0, 0, 0, 0, 0, 0);
      retire_valid = 1'b1; retire_rd = 5'd3;
      checkOutput("raw_r3_retire_same_cycle", 0, 1, 1, 0);
      applyStimulus(1, 3, 1, 0, 0, 0, 0, 0, 0);
      checkOutput("r3_after_retire", 1, 0, 0, 0);

      // WAW saturation on r4, with a cancelling issue+retire along the way.
      applyStimulus(1, 0, 0, 0, 0, 4, 1, 0, 0);
      checkOutput("waw_r4_1", 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 4, 1, 0, 0);
      checkOutput("waw_r4_2", 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 4, 1, 0, 0);
      retire_valid = 1'b1; retire_rd = 5'd4;
      checkOutput("waw_r4_issue_and_retire", 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 4, 1, 0, 0);
      checkOutput("waw_r4_3", 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 4, 1, 0, 0);
      checkOutput("waw_r4_saturated", 0, 1, 2, 0);
      applyStimulus(0, 0, 0, 0, 0, 4, 1, 0, 0);
      checkOutput("waw_cause_without_valid", 0, 0, 2, 0);
      applyStimulus(1, 4, 1, 0, 0, 4, 1, 0, 0);
      retire_valid = 1'b1; retire_rd = 5'd4;
      checkOutput("raw_over_struct", 0, 1, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      retire_valid = 1'b1; retire_rd = 5'd4;
      checkOutput("drain_r4_a", 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      retire_valid = 1'b1; retire_rd = 5'd4;
      checkOutput("drain_r4_b", 1, 0, 0, 0);

      // Memory occupancy limit of one.
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0);
      checkOutput("load_issue", 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0);
      checkOutput("store_blocked", 0, 1, 2, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0);
      mem_done = 1'b1;
      checkOutput("store_blocked_mem_done", 0, 1, 2, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0);
      checkOutput("store_issue", 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      mem_done = 1'b1;
      checkOutput("store_done", 1, 0, 0, 0);

      // Taken branch (also writing r9): control outranks RAW, then a two-cycle shadow.
      applyStimulus(1, 0, 0, 0, 0, 9, 1, 0, 1);
      checkOutput("branch_issue", 1, 0, 0, 0);
      applyStimulus(1, 9, 1, 0, 0, 0, 0, 0, 0);
      checkOutput("ctrl_over_raw", 0, 1, 3, 0);
      applyStimulus(1, 9, 1, 0, 0, 0, 0, 0, 0);
      ctrl_resolve = 1'b1; ctrl_taken = 1'b1;
      checkOutput("taken_resolve_N", 0, 1, 3, 0);
      applyStimulus(1, 9, 1, 0, 0, 0, 0, 0, 0);
      retire_valid = 1'b1; retire_rd = 5'd9;
      checkOutput("shadow_N1", 0, 1, 3, 0);
      applyStimulus(1, 9, 1, 0, 0, 0, 0, 0, 0);
      checkOutput("shadow_N2", 0, 1, 3, 0);
      applyStimulus(1, 9, 1, 0, 0, 0, 0, 0, 0);
      checkOutput("shadow_over_N3", 1, 0, 0, 0);

      // Not-taken branch resumes the next cycle.
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
      checkOutput("branch2_issue", 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
      ctrl_resolve = 1'b1; ctrl_taken = 1'b0;
      checkOutput("not_taken_N", 0, 1, 3, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("not_taken_N1", 1, 0, 0, 0);

      // Retire to r0 is ignored; retire to idle r12 sets a sticky error.
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      retire_valid = 1'b1; retire_rd = 5'd0;
      checkOutput("retire_r0", 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      retire_valid = 1'b1; retire_rd = 5'd12;
      checkOutput("retire_r0_no_error", 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("retire_idle_error", 1, 0, 0, 1);
      applyStimulus(1, 0, 0, 0, 0, 10, 1, 0, 0);
      checkOutput("error_held", 1, 0, 0, 1);

      // Reset while stalled on r10 clears tracking and the error.
      applyStimulus(1, 10, 1, 0, 0, 0, 0, 0, 0);
      checkOutput("stall_before_reset", 0, 1, 1, 1);
      reset = 1'b1;
      applyStimulus(1, 10, 1, 0, 0, 0, 0, 0, 0);
      reset = 1'b0;
      checkOutput("after_mid_reset", 1, 0, 0, 0);

      // Memory-done and resolve with nothing outstanding both flag errors.
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      mem_done = 1'b1;
      checkOutput("mem_done_idle", 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("mem_underflow_error", 1, 0, 0, 1);
      reset = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      ctrl_resolve = 1'b1;
      checkOutput("resolve_idle", 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("resolve_underflow_error", 1, 0, 0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
